// File: rtl/nanci_phase_ctrl.sv
// nanci_phase_ctrl: global sequencer for the Nanci PE mesh (memory clear, then shearsort row/column phases).
// Latency: busy for 2^ADDR_WIDTH + (2*LOG_N+1)*SORT_CYCLES non-held cycles after start, then one-cycle o_done.
// Backpressure: i_hold freezes all progress (o_sort_en forced low); i_abort returns to IDLE. Optional macro: NANCI_CYCLE_CNT_EN.
module nanci_phase_ctrl #(
  parameter int N           = 4,
  parameter int LOG_N       = 2,
  parameter int SORT_CYCLES = 4,
  parameter int ADDR_WIDTH  = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic                              i_hold,
  input  logic                              i_abort,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_clr_en,
  output logic [ADDR_WIDTH-1:0]             o_clr_addr,
  output logic [1:0]                        o_dir,
  output logic                              o_parity,
  output logic                              o_sort_en,
  output logic [$clog2(2*LOG_N+2)-1:0]      o_phase,
  output logic                              o_last_phase
`ifdef NANCI_CYCLE_CNT_EN
  ,
  output logic [15:0]                       o_cycles
`endif
);

  localparam int PHASE_W = $clog2(2*LOG_N+2);
  localparam int STEP_W  = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;

  localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(2*LOG_N);
  localparam logic [STEP_W-1:0]     STEP_LAST  = STEP_W'(SORT_CYCLES-1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = {ADDR_WIDTH{1'b1}};

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_H    = 2'b01;
  localparam logic [1:0] DIR_V    = 2'b10;

  // The schedule length is derived from LOG_N, so it must really be log2 of the mesh side.
  if ((1 << LOG_N) != N) begin : g_bad_log_n
    $error("nanci_phase_ctrl: LOG_N must equal log2(N)");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ROW,
    S_COL,
    S_DONE
  } state_t;

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [PHASE_W-1:0]  phase_nxt;

  assign phase_nxt = o_phase + 1'b1;

  // Compare-exchange enable is the only unregistered output so a hold stalls the PEs in the same cycle.
  assign o_sort_en = ((state == S_ROW) || (state == S_COL)) && !i_hold;

  // Sequencer: state, step counter and every registered output; abort outranks hold and start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      step         <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_clr_en     <= 1'b0;
      o_clr_addr   <= '0;
      o_dir        <= DIR_NONE;
      o_parity     <= 1'b0;
      o_phase      <= '0;
      o_last_phase <= 1'b0;
    end else if (i_abort) begin
      state        <= S_IDLE;
      step         <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_clr_en     <= 1'b0;
      o_clr_addr   <= '0;
      o_dir        <= DIR_NONE;
      o_parity     <= 1'b0;
      o_phase      <= '0;
      o_last_phase <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state      <= S_CLEAR;
            o_busy     <= 1'b1;
            o_clr_en   <= 1'b1;
            o_clr_addr <= '0;
          end
        end
        S_CLEAR: begin
          if (!i_hold) begin
            if (o_clr_addr == ADDR_LAST) begin
              // Memory fully cleared: enter the first row phase.
              state        <= S_ROW;
              o_clr_en     <= 1'b0;
              o_clr_addr   <= '0;
              o_dir        <= DIR_H;
              o_phase      <= '0;
              o_last_phase <= (LAST_PHASE == '0);
              step         <= '0;
              o_parity     <= 1'b0;
            end else begin
              o_clr_addr <= o_clr_addr + 1'b1;
            end
          end
        end
        S_ROW, S_COL: begin
          if (!i_hold) begin
            if (step == STEP_LAST) begin
              step     <= '0;
              o_parity <= 1'b0;
              if (o_phase == LAST_PHASE) begin
                state        <= S_DONE;
                o_busy       <= 1'b0;
                o_done       <= 1'b1;
                o_dir        <= DIR_NONE;
                o_phase      <= '0;
                o_last_phase <= 1'b0;
              end else begin
                // Even phases sort rows, odd phases sort columns.
                o_phase      <= phase_nxt;
                o_last_phase <= (phase_nxt == LAST_PHASE);
                if (phase_nxt[0]) begin
                  state <= S_COL;
                  o_dir <= DIR_V;
                end else begin
                  state <= S_ROW;
                  o_dir <= DIR_H;
                end
              end
            end else begin
              step     <= step + 1'b1;
              o_parity <= ~o_parity;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_done <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef NANCI_CYCLE_CNT_EN
  // Busy-cycle counter: cleared by an accepted start, saturates, and keeps its value once idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_cycles <= '0;
    end else if ((state == S_IDLE) && i_start && !i_abort) begin
      o_cycles <= '0;
    end else if (o_busy && (o_cycles != 16'hFFFF)) begin
      o_cycles <= o_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nanci_phase_ctrl.sv
// tb_nanci_phase_ctrl: self-checking bench for nanci_phase_ctrl (table run, corner sequences, random vs model).
// Latency: one DUT clock per stimulus step; outputs sampled on the falling edge.
// Backpressure: exercised through i_hold/i_abort in directed and random stimulus.
module tb_nanci_phase_ctrl;

  localparam int N           = 4;
  localparam int LOG_N       = 2;
  localparam int SORT_CYCLES = 4;
  localparam int ADDR_WIDTH  = 3;
  localparam int CLR         = 1 << ADDR_WIDTH;
  localparam int NPH         = 2*LOG_N + 1;
  localparam int TOTAL       = CLR + NPH*SORT_CYCLES;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          i_start = 1'b0;
  logic                          i_hold = 1'b0;
  logic                          i_abort = 1'b0;
  logic                          o_busy, o_done, o_clr_en, o_parity, o_sort_en, o_last_phase;
  logic [ADDR_WIDTH-1:0]         o_clr_addr;
  logic [1:0]                    o_dir;
  logic [$clog2(2*LOG_N+2)-1:0]  o_phase;
`ifdef NANCI_CYCLE_CNT_EN
  logic [15:0]                   o_cycles;
`endif

  nanci_phase_ctrl #(
    .N(N), .LOG_N(LOG_N), .SORT_CYCLES(SORT_CYCLES), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_hold(i_hold), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_clr_en(o_clr_en), .o_clr_addr(o_clr_addr),
    .o_dir(o_dir), .o_parity(o_parity), .o_sort_en(o_sort_en), .o_phase(o_phase),
    .o_last_phase(o_last_phase)
`ifdef NANCI_CYCLE_CNT_EN
    , .o_cycles(o_cycles)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a run is just "k non-held busy cycles elapsed"; outputs follow arithmetically.
  bit m_run;
  bit m_done;
  int m_k;
`ifdef NANCI_CYCLE_CNT_EN
  int m_cyc;
`endif
  bit cur_s, cur_h, cur_a;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_k    = 0;
`ifdef NANCI_CYCLE_CNT_EN
    m_cyc  = 0;
`endif
  endtask

  task automatic model_edge(input bit s, input bit h, input bit a);
`ifdef NANCI_CYCLE_CNT_EN
    if (!m_run && !m_done && s && !a) m_cyc = 0;
    else if (m_run && m_cyc < 65535) m_cyc++;
`endif
    if (a) begin
      m_run = 1'b0; m_done = 1'b0; m_k = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_run) begin
      if (!h) begin
        m_k++;
        if (m_k == TOTAL) begin
          m_run = 1'b0; m_done = 1'b1; m_k = 0;
        end
      end
    end else if (s) begin
      m_run = 1'b1; m_k = 0;
    end
  endtask

  // Drive one cycle of inputs and compare every output against the model at the falling edge.
  task automatic cyc_begin(input bit s, input bit h, input bit a);
    int e_clr, e_addr, e_dir, e_par, e_ph, e_last, e_sort, j, ph, st;
    cur_s = s; cur_h = h; cur_a = a;
    i_start = s; i_hold = h; i_abort = a;
    @(negedge clk);
    e_clr = 0; e_addr = 0; e_dir = 0; e_par = 0; e_ph = 0; e_last = 0; e_sort = 0;
    if (m_run) begin
      if (m_k < CLR) begin
        e_clr  = 1;
        e_addr = m_k;
      end else begin
        j      = m_k - CLR;
        ph     = j / SORT_CYCLES;
        st     = j % SORT_CYCLES;
        e_dir  = (ph % 2 == 0) ? 1 : 2;
        e_par  = st % 2;
        e_ph   = ph;
        e_last = (ph == NPH-1) ? 1 : 0;
        e_sort = h ? 0 : 1;
      end
    end
    chk("m_busy", int'(o_busy), int'(m_run));
    chk("m_done", int'(o_done), int'(m_done));
    chk("m_clr_en", int'(o_clr_en), e_clr);
    chk("m_clr_addr", int'(o_clr_addr), e_addr);
    chk("m_dir", int'(o_dir), e_dir);
    chk("m_parity", int'(o_parity), e_par);
    chk("m_phase", int'(o_phase), e_ph);
    chk("m_last_phase", int'(o_last_phase), e_last);
    chk("m_sort_en", int'(o_sort_en), e_sort);
`ifdef NANCI_CYCLE_CNT_EN
    chk("m_cycles", int'(o_cycles), m_cyc);
`endif
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_edge(cur_s, cur_h, cur_a);
    #1;
  endtask

  task automatic step(input bit s, input bit h, input bit a);
    cyc_begin(s, h, a);
    cyc_end();
  endtask

  // Let a run finish with quiet inputs; an overrun counts as a failure.
  task automatic run_to_idle(input int limit);
    int n;
    n = 0;
    while ((m_run || m_done) && n < limit) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("run_to_idle_timeout", int'(m_run || m_done), 0);
  endtask

  typedef struct {
    int cyc, busy, done, clr_en, addr, dir, par, ph, last, sort;
  } vec_t;

  vec_t tab[15];

  initial begin
    int ti, done_at, busy_cnt, done_cnt;

    tab[0]  = '{0,  0,0,0,0,0,0,0,0,0};
    tab[1]  = '{1,  1,0,1,0,0,0,0,0,0};
    tab[2]  = '{5,  1,0,1,4,0,0,0,0,0};
    tab[3]  = '{8,  1,0,1,7,0,0,0,0,0};
    tab[4]  = '{9,  1,0,0,0,1,0,0,0,1};
    tab[5]  = '{10, 1,0,0,0,1,1,0,0,1};
    tab[6]  = '{12, 1,0,0,0,1,1,0,0,1};
    tab[7]  = '{13, 1,0,0,0,2,0,1,0,1};
    tab[8]  = '{15, 1,0,0,0,2,0,1,0,1};
    tab[9]  = '{16, 1,0,0,0,2,1,1,0,1};
    tab[10] = '{21, 1,0,0,0,2,0,3,0,1};
    tab[11] = '{25, 1,0,0,0,1,0,4,1,1};
    tab[12] = '{28, 1,0,0,0,1,1,4,1,1};
    tab[13] = '{29, 0,1,0,0,0,0,0,0,0};
    tab[14] = '{30, 0,0,0,0,0,0,0,0,0};

    // Power-up reset: outputs low as soon as rst falls.
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_dir", int'(o_dir), 0);
    chk("rst_phase", int'(o_phase), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Nominal run against the vector table.
    ti = 0; busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c <= 30; c++) begin
      cyc_begin(c == 0, 1'b0, 1'b0);
      if (o_busy) busy_cnt++;
      if (o_done) done_cnt++;
      if (ti < 15 && tab[ti].cyc == c) begin
        chk("tab_busy", int'(o_busy), tab[ti].busy);
        chk("tab_done", int'(o_done), tab[ti].done);
        chk("tab_clr_en", int'(o_clr_en), tab[ti].clr_en);
        chk("tab_clr_addr", int'(o_clr_addr), tab[ti].addr);
        chk("tab_dir", int'(o_dir), tab[ti].dir);
        chk("tab_parity", int'(o_parity), tab[ti].par);
        chk("tab_phase", int'(o_phase), tab[ti].ph);
        chk("tab_last_phase", int'(o_last_phase), tab[ti].last);
        chk("tab_sort_en", int'(o_sort_en), tab[ti].sort);
        ti++;
      end
      cyc_end();
    end
    chk("tab_consumed", ti, 15);
    chk("run1_busy_cycles", busy_cnt, 28);
    chk("run1_done_pulses", done_cnt, 1);
`ifdef NANCI_CYCLE_CNT_EN
    chk("run1_o_cycles", int'(o_cycles), 28);
`endif

    // Hold for 3 cycles at phase 1 step 2: done slips from cycle 29 to 32.
    done_at = -1;
    for (int c = 0; c <= 40 && done_at < 0; c++) begin
      cyc_begin(c == 0, (c >= 15 && c <= 17), 1'b0);
      if (c == 16) begin
        chk("hold_phase", int'(o_phase), 1);
        chk("hold_parity", int'(o_parity), 0);
        chk("hold_sort_en", int'(o_sort_en), 0);
      end
      if (o_done) done_at = c;
      cyc_end();
    end
    chk("hold_done_cycle", done_at, 32);
`ifdef NANCI_CYCLE_CNT_EN
    chk("run2_o_cycles", int'(o_cycles), 31);
`endif
    run_to_idle(5);

    // Abort during phase 3, then restart from address 0.
    for (int c = 0; c <= 22; c++) step(c == 0, 1'b0, c == 22);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      cyc_begin(1'b0, 1'b0, 1'b0);
      if (c == 0) begin
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_dir", int'(o_dir), 0);
        chk("abort_phase", int'(o_phase), 0);
      end
      if (o_done) done_cnt++;
      cyc_end();
    end
    chk("abort_no_done", done_cnt, 0);
    step(1'b1, 1'b0, 1'b0);
    cyc_begin(1'b0, 1'b0, 1'b0);
    chk("restart_clr_addr", int'(o_clr_addr), 0);
    chk("restart_clr_en", int'(o_clr_en), 1);
    cyc_end();
    run_to_idle(40);

    // Asynchronous reset in the middle of the clear sweep.
    for (int c = 0; c < 6; c++) step(c == 0, 1'b0, 1'b0);
    cyc_begin(1'b0, 1'b0, 1'b0);
    chk("preclr_addr", int'(o_clr_addr), 5);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_clr_en", int'(o_clr_en), 0);
    chk("midrst_clr_addr", int'(o_clr_addr), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0);
    chk("postrst_idle", int'(o_busy), 0);

    // Start together with abort in IDLE stays IDLE.
    step(1'b1, 1'b0, 1'b1);
    cyc_begin(1'b0, 1'b0, 1'b0);
    chk("start_abort_busy", int'(o_busy), 0);
    cyc_end();

    // Start pulses while sorting are ignored.
    done_at = -1;
    for (int c = 0; c <= 40 && done_at < 0; c++) begin
      cyc_begin(c == 0 || c == 11 || c == 20, 1'b0, 1'b0);
      if (o_done) done_at = c;
      cyc_end();
    end
    chk("ignored_start_done_cycle", done_at, 29);
    run_to_idle(5);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nanci_phase_ctrl.md
Name: nanci_phase_ctrl

Overview:
- Global sequencer for the Nanci PE mesh.
- On start, it sweeps a memory-clear address through every PE memory word.
- It then drives the mesh through a shearsort schedule: 2*LOG_N+1 alternating row and column phases, each SORT_CYCLES steps long, with a per-step even/odd parity.
- One instance sits above the N x N PE array and broadcasts its outputs to every PE.

Parameters:
- N, 4, mesh side length.
- LOG_N, 2, log2(N); the schedule has LOG_N+1 row phases and LOG_N column phases.
- SORT_CYCLES, 4, steps per phase (≥1).
- ADDR_WIDTH, 3, PE memory address width; the clear sweep covers 2^ADDR_WIDTH words.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_hold  in  1  stall; freezes all counters and state.
- i_abort  in  1  abort; returns to IDLE.
- o_busy  out  1  high in CLEAR, ROW and COL.
- o_done  out  1  one-cycle pulse on normal completion.
- o_clr_en  out  1  memory clear strobe to PEs.
- o_clr_addr  out  ADDR_WIDTH  word address being cleared.
- o_dir  out  2  00 none, 01 horizontal (l/r compare), 10 vertical (u/d compare).
- o_parity  out  1  0 even step, 1 odd step of the transposition.
- o_sort_en  out  1  PEs perform the compare-exchange this cycle.
- o_phase  out  clog2(2*LOG_N+2)  current phase index.
- o_last_phase  out  1  current phase is phase 2*LOG_N.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs and counters 0.
- States: IDLE, CLEAR, ROW, COL, DONE. All outputs are registered, except o_sort_en, which is combinational: (state==ROW or COL) & ~i_hold.
- IDLE:
  - i_start=1 -> CLEAR next edge.
  - o_clr_addr=0.
- CLEAR:
  - o_clr_en=1; o_clr_addr increments once per non-held cycle from 0 to 2^ADDR_WIDTH-1.
  - After the last address -> ROW with phase=0, step=0, parity=0.
- ROW / COL:
  - o_dir = 01 in ROW, 10 in COL.
  - Each non-held cycle: step increments and parity toggles.
  - When step==SORT_CYCLES-1: phase increments, step=0, parity=0.
  - Even phases are ROW, odd phases are COL.
  - After phase 2*LOG_N completes -> DONE.
- DONE:
  - o_done=1 and o_busy=0 for exactly one cycle, then IDLE.
  - phase and o_dir clear to 0.
- Latency: start sampled at edge k gives o_busy=1 for exactly 2^ADDR_WIDTH + (2*LOG_N+1)*SORT_CYCLES non-held cycles, followed by the o_done pulse.
- i_hold:
  - State, step, parity, phase and clr_addr are frozen.
  - o_dir and o_clr_en hold their values; o_sort_en=0.
  - i_hold in IDLE or DONE has no effect; DONE still lasts one cycle.
- i_abort:
  - Highest priority; from any state -> IDLE next edge.
  - All outputs 0, no o_done.
  - Overrides i_hold.
  - Simultaneous i_start and i_abort in IDLE: stay IDLE.
- i_start outside IDLE is ignored (no queuing). A start held high continuously restarts the next IDLE cycle after DONE.
- Counters wrap only through explicit reload; no modular overflow is possible.
- SORT_CYCLES=1: parity stays 0 and phase advances every non-held cycle.
- Reset asserted mid-operation: immediate IDLE, same as power-up.

Optional Feature:
- Macro: NANCI_CYCLE_CNT_EN.
- Defined:
  - Adds port o_cycles, out, 16 bits.
  - Counts clk cycles with o_busy=1, held cycles included, saturating at 16'hFFFF.
  - Clears on each accepted start and on reset.
  - Holds its value after DONE or abort until the next start.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Defaults, pulse i_start at cycle 0 -> o_clr_addr=0..7 on cycles 1-8; o_dir sequence 01,10,01,10,01 with 4 cycles each on cycles 9-28; o_parity 0,1,0,1 within each phase; o_done=1 only on cycle 29; o_busy=1 for cycles 1-28.
- i_hold=1 for 3 cycles during phase 1 step 2 -> o_sort_en=0 and o_phase=1, o_parity=0 frozen; o_done delayed to cycle 32.
- i_abort during phase 3 -> next cycle o_busy=0, o_dir=00, o_phase=0, no o_done pulse; a new i_start restarts at o_clr_addr=0.
- rst=0 asserted mid-CLEAR at o_clr_addr=5 -> outputs 0 immediately, before any clock edge; after release, the machine remains IDLE until i_start.
- i_start=1 and i_abort=1 together in IDLE -> stays IDLE. i_start pulsed in ROW -> ignored; o_done still occurs at cycle 29.
- With NANCI_CYCLE_CNT_EN and run 1 -> o_cycles=28 after done. With run 2 -> o_cycles=31. Without the macro the build has no o_cycles port.
